// File: rtl/memory_ram_pipe.sv
// Single-port synchronous RAM. It has byte strobes, a pipelined read with a valid flag,
// a ready handshake, a post-reset clear sequencer and flagging of illegal requests.
module memory_ram_pipe #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       ADDR_W         = 8,
  parameter int unsigned       RD_LAT         = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL       = {DATA_W{1'b0}}
) (
  input  logic                  iRAM_CLK,
  input  logic                  iRAM_RST,
  input  logic                  iRAM_CE,
  input  logic                  iRAM_RD,
  input  logic                  iRAM_WR,
  input  logic [ADDR_W-1:0]     iRAM_ADDR,
  input  logic [DATA_W-1:0]     iRAM_DATA,
  input  logic [DATA_W/8-1:0]   iRAM_BE,
  output logic [DATA_W-1:0]     oRAM_DATA,
  output logic                  oRAM_VALID,
  output logic                  oRAM_READY,
  output logic                  oRAM_ERR
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned BE_W  = DATA_W/8;

  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_ready;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [RD_LAT-1:0]   r_vld;
  logic [DATA_W-1:0]   r_pdata [RD_LAT];
  logic                w_clr_we;
  logic                w_req_ok;
  logic                w_acc_rd;
  logic                w_acc_wr;
  logic                w_illegal;

  always_ff @(posedge iRAM_CLK) begin
    if (iRAM_RST) begin
      r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: begin
        if (r_cnt == {ADDR_W{1'b1}}) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_CLEAR;
        end
      end
      S_IDLE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_clr_we = 1'b0;
    case (r_state)
      S_CLEAR: w_clr_we = 1'b1;
      S_IDLE:  w_clr_we = 1'b0;
      default: w_clr_we = 1'b0;
    endcase
  end

  // Requests are only qualified once ready; RD and WR together is rejected.
  assign w_req_ok  = iRAM_CE & r_ready;
  assign w_acc_rd  = w_req_ok & iRAM_RD & ~iRAM_WR;
  assign w_acc_wr  = w_req_ok & iRAM_WR & ~iRAM_RD;
  assign w_illegal = w_req_ok & iRAM_RD & iRAM_WR;

  always_ff @(posedge iRAM_CLK) begin
    if (iRAM_RST) begin
      r_cnt   <= {ADDR_W{1'b0}};
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt   <= w_clr_we ? r_cnt + ADDR_W'(1) : r_cnt;
      r_ready <= (w_next_state == S_IDLE);
      r_err   <= w_illegal;
    end
  end

  always_ff @(posedge iRAM_CLK) begin
    if (!iRAM_RST) begin
      if (w_clr_we) begin
        r_mem[r_cnt] <= INIT_VAL;
      end else if (w_acc_wr) begin
        for (int k = 0; k < BE_W; k++) begin
          if (iRAM_BE[k]) begin
            r_mem[iRAM_ADDR][8*k +: 8] <= iRAM_DATA[8*k +: 8];
          end
        end
      end
    end
  end

  // Last stage only loads on a valid result, so the output holds between reads.
  always_ff @(posedge iRAM_CLK) begin
    if (iRAM_RST) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_vld[i]   <= 1'b0;
        r_pdata[i] <= {DATA_W{1'b0}};
      end
    end else begin
      r_vld[0] <= w_acc_rd;
      if (w_acc_rd) begin
        r_pdata[0] <= r_mem[iRAM_ADDR];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_pdata[i] <= r_pdata[i-1];
        end
      end
    end
  end

  assign oRAM_DATA  = r_pdata[RD_LAT-1];
  assign oRAM_VALID = r_vld[RD_LAT-1];
  assign oRAM_READY = r_ready;
  assign oRAM_ERR   = r_err;

endmodule
